// File: rtl/result_store.sv
// Result capture buffer: collects producer words, then steps through them for display.
// Optional running sum of accepted words when RESULT_STORE_SUM_EN is defined.
module result_store #(
  parameter int unsigned DATA_W = 21,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              done,
  input  logic              next_btn,
  input  logic              clear,
  output logic              mode,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              overflow,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_valid
`ifdef RESULT_STORE_SUM_EN
  ,
  output logic [DATA_W+ADDR_W:0] sum
`endif
);

  localparam int unsigned CNT_W = ADDR_W + 1;
`ifdef RESULT_STORE_SUM_EN
  localparam int unsigned SUM_W = DATA_W + ADDR_W + 1;
`endif

  typedef enum logic {
    COLLECT = 1'b0,
    READOUT = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              nb_q;

  logic              step_c;
  logic              accept_c;
  logic              drop_c;
  logic              wrap_c;
  logic              has_data_c;

  // Next-state and per-cycle qualifiers; clear dominates done and wr_req.
  always_comb begin
    state_d    = state_q;
    step_c     = next_btn & ~nb_q;
    has_data_c = (count != '0);
    accept_c   = (state_q == COLLECT) && wr_req && !full && !clear;
    drop_c     = (state_q == COLLECT) && wr_req && full && !clear;
    wrap_c     = ({1'b0, rd_ptr_q} == (count - CNT_W'(1)));
    if (clear) begin
      state_d = COLLECT;
    end else begin
      case (state_q)
        COLLECT: if (done) state_d = READOUT;
        READOUT: state_d = READOUT;
        default: state_d = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  assign mode = (state_q == READOUT);

  // Storage array; contents are not cleared, only the pointers are.
  always_ff @(posedge clock) begin
    if (!reset && accept_c) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers, occupancy, status flags and the registered display port.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count     <= '0;
      full      <= 1'b0;
      overflow  <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      nb_q      <= 1'b0;
    end else begin
      nb_q <= next_btn;
      if (clear) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count     <= '0;
        full      <= 1'b0;
        overflow  <= 1'b0;
        out_data  <= '0;
        out_index <= '0;
        out_valid <= 1'b0;
      end else begin
        if (accept_c) begin
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          count    <= count + CNT_W'(1);
          full     <= (count == CNT_W'(DEPTH - 1));
        end
        if (drop_c) overflow <= 1'b1;

        // Stepping wraps at the stored word count, not at DEPTH.
        if ((state_q == COLLECT) && done) begin
          rd_ptr_q <= '0;
        end else if ((state_q == READOUT) && step_c && has_data_c) begin
          rd_ptr_q <= wrap_c ? '0 : rd_ptr_q + ADDR_W'(1);
        end

        if (state_q == READOUT) begin
          out_data  <= mem[rd_ptr_q];
          out_index <= rd_ptr_q;
          out_valid <= has_data_c;
        end else begin
          out_data  <= '0;
          out_index <= '0;
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef RESULT_STORE_SUM_EN
  // Running total of accepted words only.
  always_ff @(posedge clock) begin
    if (reset || clear) sum <= '0;
    else if (accept_c)  sum <= sum + SUM_W'(wr_data);
  end
`endif

endmodule

// File: tb/tb_result_store.sv
// Directed plus random bench for result_store against a queue-based reference model.
module tb_result_store;

  localparam int unsigned DATA_W = 21;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              wr_req;
  logic [DATA_W-1:0] wr_data;
  logic              done;
  logic              next_btn;
  logic              clear;
  logic              mode;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              overflow;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_valid;
`ifdef RESULT_STORE_SUM_EN
  logic [DATA_W+ADDR_W:0] sum;
`endif

  result_store #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset), .wr_req(wr_req), .wr_data(wr_data),
    .done(done), .next_btn(next_btn), .clear(clear), .mode(mode),
    .count(count), .full(full), .overflow(overflow), .out_data(out_data),
    .out_index(out_index), .out_valid(out_valid)
`ifdef RESULT_STORE_SUM_EN
    , .sum(sum)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: stored words as a queue, display position as an integer.
  logic [DATA_W-1:0] m_q[$];
  bit                m_readout;
  bit                m_ovf;
  int                m_pos;
  bit                m_btn_prev;
  longint            m_sum;
  logic [DATA_W-1:0] e_data;
  int                e_index;
  bit                e_valid;
  bit                e_data_known;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    bit pressed;
    if (reset) begin
      m_q.delete();
      m_readout = 0; m_ovf = 0; m_pos = 0; m_btn_prev = 0; m_sum = 0;
      e_data = '0; e_index = 0; e_valid = 0; e_data_known = 1;
      return;
    end
    pressed    = next_btn && !m_btn_prev;
    m_btn_prev = next_btn;
    // Display shows what the model pointed at before this edge.
    if (m_readout) begin
      e_index      = m_pos;
      e_valid      = (m_q.size() != 0);
      e_data_known = (m_q.size() != 0);
      e_data       = (m_q.size() != 0) ? m_q[m_pos] : '0;
    end else begin
      e_index = 0; e_valid = 0; e_data = '0; e_data_known = 1;
    end
    if (clear) begin
      m_q.delete();
      m_readout = 0; m_ovf = 0; m_pos = 0; m_sum = 0;
      e_index = 0; e_valid = 0; e_data = '0; e_data_known = 1;
    end else if (!m_readout) begin
      if (wr_req) begin
        if (m_q.size() < DEPTH) begin
          m_q.push_back(wr_data);
          m_sum += longint'(wr_data);
        end else begin
          m_ovf = 1;
        end
      end
      if (done) begin
        m_readout = 1;
        m_pos     = 0;
      end
    end else if (pressed && m_q.size() != 0) begin
      m_pos = (m_pos + 1) % m_q.size();
    end
  endtask

  task automatic check_all();
    check("mode", 64'(mode), 64'(m_readout));
    check("count", 64'(count), 64'(m_q.size()));
    check("full", 64'(full), 64'(m_q.size() == DEPTH));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("out_index", 64'(out_index), 64'(e_index));
    if (e_data_known) check("out_data", 64'(out_data), 64'(e_data));
`ifdef RESULT_STORE_SUM_EN
    check("sum", 64'(sum), 64'(m_sum));
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    model_update();
    check_all();
  endtask

  task automatic write_word(input logic [DATA_W-1:0] d);
    wr_req = 1'b1; wr_data = d;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic enter_readout();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
  endtask

  // One press held 5 cycles; the new word is visible after the second edge.
  task automatic press();
    next_btn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    next_btn = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; wr_req = 1'b0; wr_data = '0; done = 1'b0;
    next_btn = 1'b0; clear = 1'b0;
    tick();
    check("rst_count", 64'(count), 64'd0);
    check("rst_mode", 64'(mode), 64'd0);
    reset = 1'b0;

    // Three writes then a done pulse.
    write_word(21'h00001);
    write_word(21'h1F000);
    write_word(21'h1FFFFF);
    enter_readout();
    check("ro_count", 64'(count), 64'd3);
    check("ro_mode", 64'(mode), 64'd1);
    check("ro_idx0", 64'(out_index), 64'd0);
    check("ro_data0", 64'(out_data), 64'h00001);
    check("ro_valid", 64'(out_valid), 64'd1);

    press();
    check("step1", 64'(out_data), 64'h1F000);
    press();
    check("step2", 64'(out_data), 64'h1FFFFF);
    press();
    check("step3_wrap", 64'(out_data), 64'h00001);
    check("step3_idx", 64'(out_index), 64'd0);

    // Fill past capacity.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      write_word(DATA_W'(i));
      if (i == 16) check("full_at16", 64'(full), 64'd1);
      if (i == 16) check("ovf_before17", 64'(overflow), 64'd0);
    end
    check("ovf_at17", 64'(overflow), 64'd1);
    check("count_sat", 64'(count), 64'd16);
    enter_readout();
    for (int i = 0; i < 15; i++) press();
    check("idx15", 64'(out_index), 64'd15);
    check("data15", 64'(out_data), 64'd16);
    press();
    check("no_word17", 64'(out_data), 64'd1);

    // Write coincident with done is kept.
    clear = 1'b1; tick(); clear = 1'b0;
    write_word(21'h00055);
    wr_req = 1'b1; wr_data = 21'h0ABCD; done = 1'b1;
    tick();
    wr_req = 1'b0; done = 1'b0;
    check("wd_count", 64'(count), 64'd2);
    tick();
    press();
    check("wd_idx1", 64'(out_index), 64'd1);
    check("wd_data1", 64'(out_data), 64'h0ABCD);

    // clear beats done in readout.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < 4; i++) write_word(DATA_W'($urandom));
    enter_readout();
    check("cd_count4", 64'(count), 64'd4);
    clear = 1'b1; done = 1'b1;
    tick();
    clear = 1'b0; done = 1'b0;
    check("cd_mode", 64'(mode), 64'd0);
    check("cd_count", 64'(count), 64'd0);
    check("cd_ovf", 64'(overflow), 64'd0);
    check("cd_valid", 64'(out_valid), 64'd0);
    tick();
    check("cd_stay", 64'(mode), 64'd0);

    // Reset in the middle of readout.
    write_word(21'd5);
    write_word(21'd7);
`ifdef RESULT_STORE_SUM_EN
    check("sum12", 64'(sum), 64'd12);
`endif
    write_word(21'd9);
    enter_readout();
    press();
    press();
    check("mid_idx2", 64'(out_index), 64'd2);
    check("mid_data2", 64'(out_data), 64'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_mode", 64'(mode), 64'd0);
    check("mr_data", 64'(out_data), 64'd0);
    check("mr_idx", 64'(out_index), 64'd0);
    check("mr_valid", 64'(out_valid), 64'd0);
    check("mr_count", 64'(count), 64'd0);
`ifdef RESULT_STORE_SUM_EN
    check("mr_sum", 64'(sum), 64'd0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      wr_req  = ($urandom_range(0, 1) == 1);
      wr_data = DATA_W'($urandom);
      done    = ($urandom_range(0, 19) == 0);
      clear   = ($urandom_range(0, 59) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) next_btn = ~next_btn;
      tick();
    end
    reset = 1'b0; clear = 1'b0; done = 1'b0; wr_req = 1'b0; next_btn = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/result_store.md
Name: result_store

Overview:
- Downstream consumer of the main compute datapath's write port.
- Captures each 21-bit result presented on wr_req/wr_data into a small on-chip buffer while the computation runs.
- When the producer signals done, switches to readout mode. A push-button step input then walks through the stored results one at a time for board display.

Parameters:
DATA_W, 21, width of each result word (matches producer wr_data)
DEPTH, 16, number of storable words; power of two
ADDR_W, 4, pointer width, log2(DEPTH)

Ports:
clock  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
wr_req  input  1  producer write strobe; one word per cycle high
wr_data  input  DATA_W  result word, valid when wr_req=1
done  input  1  producer completion flag (level or pulse)
next_btn  input  1  push-button step level, already synchronised to clock
clear  input  1  discard contents, return to collect mode
mode  output  1  0=COLLECT, 1=READOUT
count  output  ADDR_W+1  words stored, 0..DEPTH
full  output  1  count==DEPTH
overflow  output  1  sticky: a write was dropped because buffer full
out_data  output  DATA_W  word at out_index (READOUT only, else 0)
out_index  output  ADDR_W  index of displayed word
out_valid  output  1  1 in READOUT when count>0

Behaviour:
- Reset (synchronous, active-high): mode=COLLECT, wr_ptr=0, rd_ptr=0, count=0, overflow=0, out_data=0, out_index=0, out_valid=0, next_btn edge register=0. Memory contents are don't-care.
- FSM states COLLECT and READOUT.
- COLLECT, wr_req=1 and not full: mem[wr_ptr]<=wr_data, wr_ptr+1, count+1; takes effect at that edge.
- COLLECT, wr_req=1 and full: word dropped; overflow<=1 (sticky until reset/clear); count stays DEPTH.
- COLLECT, done=1: next state READOUT, rd_ptr<=0. A wr_req in the same cycle is accepted first, so the last word is not lost.
- READOUT: wr_req ignored; count and overflow frozen; done ignored.
- Step detection: next_btn registered (nb_q). A step is next_btn & ~nb_q, one pulse per press. Holding the button gives one step.
- READOUT, step: rd_ptr<=rd_ptr+1, or 0 if rd_ptr==count-1 (wrap within stored words, not DEPTH). A step is ignored when count==0.
- Registered read: out_data<=mem[rd_ptr] and out_index<=rd_ptr every cycle in READOUT. Outputs lag rd_ptr by 1 cycle:
  - index 0 appears 2 edges after done is sampled;
  - each new word appears 2 edges after next_btn is first sampled high.
- out_valid<=(mode==READOUT)&&(count!=0), registered alongside out_data. In COLLECT, out_data=0 and out_valid=0.
- clear=1 (either state): next state COLLECT; wr_ptr, rd_ptr, count, overflow <= 0; outputs 0. clear beats done and wr_req in the same cycle.
- reset beats everything; reset mid-readout returns to the reset state in one edge.
- count width ADDR_W+1 so DEPTH is representable. Pointers wrap modulo DEPTH naturally.

Optional Feature:
- Macro RESULT_STORE_SUM_EN.
- Defined: adds output sum [DATA_W+ADDR_W:0].
  - Reset/clear to 0.
  - sum<=sum+wr_data on every accepted write; dropped writes not added.
  - Frozen in READOUT.
  - Unsigned, zero-extended, no saturation needed at this width.
- Undefined: port and adder absent; all other behaviour identical.

Test Plan:
- Reset then 3 writes (0x00001, 0x1F000, 0x1FFFFF), then done pulse -> count=3, mode=1; 2 edges after done, out_index=0, out_data=0x00001, out_valid=1.
- In READOUT press next_btn 3 times (held 5 cycles each) -> out_data sequence 0x1F000, 0x1FFFFF, 0x00001 (wraps at count), one step per press.
- 17 consecutive wr_req with data 1..17 -> full=1 after 16th; overflow=1 after 17th; readout index 15 shows 16; word 17 absent.
- wr_req with 0x0ABCD and done in same cycle after 1 prior write -> count=2, index 1 readable as 0x0ABCD.
- clear and done asserted together in READOUT with count=4 -> mode=0, count=0, overflow=0, out_valid=0; done ignored.
- reset asserted mid-readout at index 2 -> next edge all outputs 0, mode=0; with RESULT_STORE_SUM_EN, writes 5,7 give sum=12 and sum returns to 0 on reset.
